// File: rtl/uart_tx_tick_pkg.sv
// uart_tx_tick shared definitions: FSM encoding,
// frame-format limits and the parity helper.
package uart_tx_tick_pkg;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 8;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  typedef logic [2:0] tx_state_t;

  localparam tx_state_t ST_IDLE   = 3'd0;
  localparam tx_state_t ST_ARMED  = 3'd1;
  localparam tx_state_t ST_START  = 3'd2;
  localparam tx_state_t ST_DATA   = 3'd3;
  localparam tx_state_t ST_PARITY = 3'd4;
  localparam tx_state_t ST_STOP   = 3'd5;

  function automatic logic frame_parity(
    input logic [DATA_BITS_MAX-1:0] data,
    input logic                     odd
  );
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_tick.sv
// UART transmitter, LSB first, bit timing taken
// from the external one-cycle BAUD_TICK strobe.
module uart_tx_tick
  import uart_tx_tick_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 CLK_IN,
  input  logic                 RST,
  input  logic                 BAUD_TICK,
  input  logic [DATA_BITS-1:0] TX_DATA,
  input  logic                 TX_VALID,
  output logic                 TX_READY,
  output logic                 TXD,
  output logic                 BUSY,
  output logic                 TX_DONE
);

  localparam int NBITS =
    (DATA_BITS < DATA_BITS_MIN) ? DATA_BITS_MIN :
    (DATA_BITS > DATA_BITS_MAX) ? DATA_BITS_MAX :
    DATA_BITS;

  localparam logic [2:0] LAST_BIT = 3'(NBITS - 1);

  localparam logic LAST_STOP =
    (STOP_BITS > STOP_BITS_MIN) ? 1'b1 : 1'b0;

  localparam logic ODD = (PARITY_ODD != 0);
  localparam logic PEN = (PARITY_EN != 0);

  tx_state_t              state;
  logic [DATA_BITS-1:0]   shreg;
  logic [2:0]             bit_cnt;
  logic                   stop_cnt;
  logic                   par_bit;
  logic                   accept;
  logic [DATA_BITS_MAX-1:0] data_ext;

  assign accept = TX_VALID && TX_READY;

  always_comb begin
    data_ext = '0;
    data_ext[DATA_BITS-1:0] = TX_DATA;
  end

  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_bit  <= 1'b0;
      TXD      <= 1'b1;
      TX_READY <= 1'b0;
      BUSY     <= 1'b0;
      TX_DONE  <= 1'b0;
    end else begin
      TX_DONE <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          TXD      <= 1'b1;
          TX_READY <= 1'b1;
          // A tick coinciding with accept is ignored:
          // ARMED waits for the next one.
          if (accept) begin
            shreg    <= TX_DATA;
            par_bit  <= frame_parity(data_ext, ODD);
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            state    <= ST_ARMED;
            BUSY     <= 1'b1;
            TX_READY <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (BAUD_TICK) begin
            state <= ST_START;
            TXD   <= 1'b0;
          end
        end
        ST_START: begin
          if (BAUD_TICK) begin
            state <= ST_DATA;
            TXD   <= shreg[0];
            shreg <= shreg >> 1;
          end
        end
        ST_DATA: begin
          if (BAUD_TICK) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              if (PEN) begin
                state <= ST_PARITY;
                TXD   <= par_bit;
              end else begin
                state <= ST_STOP;
                TXD   <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              TXD     <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (BAUD_TICK) begin
            state <= ST_STOP;
            TXD   <= 1'b1;
          end
        end
        ST_STOP: begin
          TXD <= 1'b1;
          if (BAUD_TICK) begin
            if (stop_cnt == LAST_STOP) begin
              stop_cnt <= 1'b0;
              state    <= ST_IDLE;
              TX_DONE  <= 1'b1;
              BUSY     <= 1'b0;
              TX_READY <= 1'b1;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          TXD      <= 1'b1;
          BUSY     <= 1'b0;
          TX_READY <= 1'b0;
        end
      endcase
    end
  end

endmodule
